// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared definitions: FSM states,
// access sizes and lane/misalign helpers.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FAULT
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [3:0] be_gen(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misalign_chk(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'd0);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: byte enables, lane-shifted
// store data and misalignment for a data access.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic        misalign
);

  // Pure lane steering from size and byte offset
  always_comb begin
    be       = be_gen(size, off);
    wdata_sh = wdata << {off, 3'b000};
    misalign = misalign_chk(size, off);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the unified memory:
// one outstanding access, data priority, fetch anti-starve.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_misalign,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_be,
  input  logic [31:0]       m_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          side_q, side_d;
  logic          st_q, st_d;

  logic [3:0]    la_be;
  logic [31:0]   la_wdata;
  logic          la_mis;
  logic          starved;
  logic          unused_addr_hi;

  assign starved = (starve_q == SW'(STARVE_MAX));

  // Address bits above the memory depth wrap
  assign unused_addr_hi = ^{i_addr[31:ADDR_W+2],
                            d_addr[31:ADDR_W+2]};

  mem_lane_align u_lane (
    .size     (d_size),
    .off      (d_addr[1:0]),
    .wdata    (d_wdata),
    .be       (la_be),
    .wdata_sh (la_wdata),
    .misalign (la_mis)
  );

  // Arbitration, memory strobe and response generation;
  // grants are masked while rst is high so every
  // output reads 0 during reset
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    side_d     = side_q;
    st_d       = st_q;
    i_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    i_misalign = 1'b0;
    d_gnt      = 1'b0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    d_misalign = 1'b0;
    m_en       = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_be       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!rst && i_req && (!d_req || starved)) begin
          i_gnt    = 1'b1;
          starve_d = '0;
          side_d   = 1'b0;
          st_d     = 1'b0;
          if (i_addr[1:0] != 2'd0) begin
            state_d = S_FAULT;
          end else begin
            m_en    = 1'b1;
            m_addr  = i_addr[ADDR_W+1:2];
            m_be    = 4'hF;
            cnt_d   = 3'd1;
            state_d = S_WAIT;
          end
        end else if (!rst && d_req) begin
          d_gnt  = 1'b1;
          side_d = 1'b1;
          st_d   = d_we;
          if (i_req && !starved)
            starve_d = starve_q + 1'b1;
          if (la_mis) begin
            state_d = S_FAULT;
          end else begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr[ADDR_W+1:2];
            m_be    = la_be;
            m_wdata = la_wdata;
            cnt_d   = 3'd1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'(MEM_LAT)) begin
          state_d = S_IDLE;
          if (side_q) begin
            d_rvalid = 1'b1;
            d_rdata  = st_q ? 32'd0 : m_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = m_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_FAULT: begin
        state_d = S_IDLE;
        if (side_q) begin
          d_rvalid   = 1'b1;
          d_misalign = 1'b1;
        end else begin
          i_rvalid   = 1'b1;
          i_misalign = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latency and starvation registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      side_q   <= 1'b0;
      st_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      side_q   <= side_d;
      st_q     <= st_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table on a
// MEM_LAT=1 instance, corner sequences on MEM_LAT=3.
module tb_mem_arbiter;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        x_en;
    logic        x_we;
    logic [15:0] x_addr;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic [31:0] x_rdata;
    logic        x_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, init_mem;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;

  logic        a_i_gnt, a_i_rvalid, a_i_misalign;
  logic        a_d_gnt, a_d_rvalid, a_d_misalign;
  logic        a_m_en, a_m_we;
  logic [31:0] a_i_rdata, a_d_rdata, a_m_wdata;
  logic [15:0] a_m_addr;
  logic [3:0]  a_m_be;
  logic [31:0] rd_a;

  logic        b_i_gnt, b_i_rvalid, b_i_misalign;
  logic        b_d_gnt, b_d_rvalid, b_d_misalign;
  logic        b_m_en, b_m_we;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_wdata;
  logic [15:0] b_m_addr;
  logic [3:0]  b_m_be;
  logic [31:0] rd_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(16), .MEM_LAT(1), .STARVE_MAX(4)
  ) u_a (
    .clk(clk), .rst(rst_a),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid),
    .i_rdata(a_i_rdata), .i_misalign(a_i_misalign),
    .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid),
    .d_rdata(a_d_rdata), .d_misalign(a_d_misalign),
    .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr),
    .m_wdata(a_m_wdata), .m_be(a_m_be), .m_rdata(rd_a)
  );

  mem_arbiter #(
    .ADDR_W(16), .MEM_LAT(3), .STARVE_MAX(4)
  ) u_b (
    .clk(clk), .rst(rst_b),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid),
    .i_rdata(b_i_rdata), .i_misalign(b_i_misalign),
    .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid),
    .d_rdata(b_d_rdata), .d_misalign(b_d_misalign),
    .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr),
    .m_wdata(b_m_wdata), .m_be(b_m_be), .m_rdata(rd_b)
  );

  // Memory models: read data registered on m_en and
  // held, so it is valid from the next cycle onward
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 256; k++) begin
        mem_a[k] <= 32'd0;
        mem_b[k] <= 32'd0;
      end
      mem_a[8'h11] <= 32'h0000_0073;
      mem_a[8'h12] <= 32'h1234_5678;
      mem_a[8'h40] <= 32'hDEAD_BEEF;
      mem_b[8'h12] <= 32'h1234_5678;
      mem_b[8'h40] <= 32'hDEAD_BEEF;
    end else begin
      if (a_m_en) begin
        for (int b = 0; b < 4; b++)
          if (a_m_we && a_m_be[b])
            mem_a[a_m_addr[7:0]][8*b +: 8]
              <= a_m_wdata[8*b +: 8];
        rd_a <= mem_a[a_m_addr[7:0]];
      end
      if (b_m_en) begin
        for (int b = 0; b < 4; b++)
          if (b_m_we && b_m_be[b])
            mem_b[b_m_addr[7:0]][8*b +: 8]
              <= b_m_wdata[8*b +: 8];
        rd_b <= mem_b[b_m_addr[7:0]];
      end
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    i_req   = !v.is_d;
    i_addr  = v.addr;
    d_req   = v.is_d;
    d_we    = v.we;
    d_size  = v.size;
    d_addr  = v.addr;
    d_wdata = v.wdata;
    #1;
    chk({p, ".i_gnt"}, a_i_gnt, !v.is_d);
    chk({p, ".d_gnt"}, a_d_gnt, v.is_d);
    chk({p, ".m_en"}, a_m_en, v.x_en);
    if (v.x_en) begin
      chk({p, ".m_we"}, a_m_we, v.x_we);
      chk({p, ".m_addr"}, a_m_addr, v.x_addr);
      chk({p, ".m_be"}, a_m_be, v.x_be);
      chk({p, ".m_wdata"}, a_m_wdata, v.x_wdata);
    end
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b0;
    #1;
    chk({p, ".rsp_m_en"}, a_m_en, 0);
    if (v.is_d) begin
      chk({p, ".d_rvalid"}, a_d_rvalid, 1);
      chk({p, ".i_rvalid"}, a_i_rvalid, 0);
      chk({p, ".d_rdata"}, a_d_rdata, v.x_rdata);
      chk({p, ".d_mis"}, a_d_misalign, v.x_mis);
    end else begin
      chk({p, ".i_rvalid"}, a_i_rvalid, 1);
      chk({p, ".d_rvalid"}, a_d_rvalid, 0);
      chk({p, ".i_rdata"}, a_i_rdata, v.x_rdata);
      chk({p, ".i_mis"}, a_i_misalign, v.x_mis);
    end
  endtask

  vec_t vecs [16];

  initial begin
    int   dcnt;
    int   rounds;
    logic overlap;
    logic seen;

    // is_d addr we size wdata | en we maddr be wdata rdata mis
    vecs[0]  = '{0, 32'h44, 0, 2, 0,
                 1, 0, 16'h11, 4'hF, 0, 32'h73, 0};
    vecs[1]  = '{1, 32'h100, 0, 2, 0,
                 1, 0, 16'h40, 4'hF, 0, 32'hDEADBEEF, 0};
    vecs[2]  = '{1, 32'h103, 1, 0, 32'hAB,
                 1, 1, 16'h40, 4'h8, 32'hAB000000, 0, 0};
    vecs[3]  = '{1, 32'h100, 0, 2, 0,
                 1, 0, 16'h40, 4'hF, 0, 32'hABADBEEF, 0};
    vecs[4]  = '{1, 32'h102, 1, 1, 32'h1234,
                 1, 1, 16'h40, 4'hC, 32'h12340000, 0, 0};
    vecs[5]  = '{1, 32'h100, 0, 1, 0,
                 1, 0, 16'h40, 4'h3, 0, 32'h1234BEEF, 0};
    vecs[6]  = '{0, 32'h46, 0, 2, 0,
                 0, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{1, 32'h101, 1, 1, 32'h5555,
                 0, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{1, 32'h100, 0, 3, 0,
                 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{1, 32'h102, 0, 2, 0,
                 0, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{0, 32'h48, 0, 2, 0,
                 1, 0, 16'h12, 4'hF, 0, 32'h12345678, 0};
    vecs[11] = '{0, 32'h40044, 0, 2, 0,
                 1, 0, 16'h11, 4'hF, 0, 32'h73, 0};
    vecs[12] = '{1, 32'h108, 1, 2, 32'hCAFEF00D,
                 1, 1, 16'h42, 4'hF, 32'hCAFEF00D, 0, 0};
    vecs[13] = '{1, 32'h108, 0, 2, 0,
                 1, 0, 16'h42, 4'hF, 0, 32'hCAFEF00D, 0};
    vecs[14] = '{1, 32'h101, 1, 0, 32'h77,
                 1, 1, 16'h40, 4'h2, 32'h00007700, 0, 0};
    vecs[15] = '{1, 32'h100, 0, 2, 0,
                 1, 0, 16'h40, 4'hF, 0, 32'h123477EF, 0};

    rst_a    = 1'b1;
    rst_b    = 1'b1;
    init_mem = 1'b1;
    i_req    = 1'b1;
    i_addr   = 32'h44;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_size   = 2'd2;
    d_addr   = 32'h0;
    d_wdata  = 32'h0;

    // Reset state, request held during reset
    @(negedge clk);
    #1;
    chk("rst.i_gnt", a_i_gnt, 0);
    chk("rst.m_en", a_m_en, 0);
    chk("rst.rvalid", {a_i_rvalid, a_d_rvalid}, 0);
    init_mem = 1'b0;
    i_req    = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;

    for (int k = 0; k < 16; k++)
      run_vec(k, vecs[k]);

    // Both requests together: data first
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'h44;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_size = 2'd2;
    d_addr = 32'h100;
    #1;
    chk("both.d_gnt", a_d_gnt, 1);
    chk("both.i_gnt", a_i_gnt, 0);
    chk("both.m_addr", a_m_addr, 16'h40);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("both.d_rvalid", a_d_rvalid, 1);
    chk("both.i_gnt_wait", a_i_gnt, 0);
    @(negedge clk);
    #1;
    chk("both.i_gnt_late", a_i_gnt, 1);
    chk("both.m_addr_i", a_m_addr, 16'h11);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("both.i_rvalid", a_i_rvalid, 1);

    // Starvation: four data wins, then fetch, twice
    @(negedge clk);
    i_req   = 1'b1;
    d_req   = 1'b1;
    dcnt    = 0;
    rounds  = 0;
    overlap = 1'b0;
    for (int c = 0; c < 60 && rounds < 2; c++) begin
      #1;
      if (a_i_gnt && a_d_gnt) overlap = 1'b1;
      if (a_d_gnt) dcnt++;
      if (a_i_gnt) begin
        chk($sformatf("starve.round%0d", rounds),
            dcnt, 4);
        dcnt = 0;
        rounds++;
      end
      @(negedge clk);
    end
    chk("starve.rounds", rounds, 2);
    chk("starve.overlap", overlap, 0);
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // MEM_LAT=3 instance: reset mid-access
    rst_a  = 1'b1;
    rst_b  = 1'b0;
    @(negedge clk);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_size = 2'd2;
    d_addr = 32'h100;
    #1;
    chk("lat3.d_gnt", b_d_gnt, 1);
    chk("lat3.m_addr", b_m_addr, 16'h40);
    chk("lat3.a_in_rst", a_d_gnt, 0);
    @(negedge clk);
    d_req = 1'b0;
    rst_b = 1'b1;
    #1;
    chk("lat3.rst_outs",
        |{b_i_gnt, b_i_rvalid, b_i_rdata,
          b_i_misalign, b_d_gnt, b_d_rvalid,
          b_d_rdata, b_d_misalign, b_m_en,
          b_m_we, b_m_addr, b_m_wdata, b_m_be}, 0);
    @(negedge clk);
    rst_b = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (b_d_rvalid) seen = 1'b1;
      @(negedge clk);
    end
    chk("lat3.no_d_rvalid", seen, 0);

    // Fresh fetch after reset, exact latency 3
    i_req  = 1'b1;
    i_addr = 32'h48;
    #1;
    chk("lat3.i_gnt", b_i_gnt, 1);
    chk("lat3.i_m_addr", b_m_addr, 16'h12);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      i_req = 1'b0;
      #1;
      chk($sformatf("lat3.i_rvalid_c%0d", k),
          b_i_rvalid, (k == 3));
    end
    chk("lat3.i_rdata", b_i_rdata, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
